// File: rtl/bram1be_client_if.sv
// Request/response bus between a client and bram1be_client.
//
// Handshake rules, identical for both channels:
//   - A transfer happens in every cycle where valid and ready are both high
//     at the rising clock edge.
//   - The source keeps valid and its payload stable until the transfer.
//   - Ready may change at any time and never depends on a future valid.
//
// The request channel carries req_we/req_addr/req_wdata.
// The response channel carries rsp_data.
interface bram1be_client_if #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int WE_WIDTH   = 1
);
    logic                  req_valid;
    logic                  req_ready;
    logic [WE_WIDTH-1:0]   req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    // Client side: issues requests and consumes responses.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    // bram1be_client side: accepts requests and produces responses.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/bram1be_client.sv
// bram1be_client: initiator for a single-ported byte-enable BRAM.
//
// Requests are passed straight through to the BRAM port. A tag shift
// register of length L = 1 + PIPELINED follows every tracked request down
// the BRAM read pipeline. When a tag reaches the end, the BRAM output word
// is pushed into a small response FIFO.
//
// Requests are credit-gated: a request is accepted only if the sum of the
// tags in flight and the words held in the FIFO is below RESP_DEPTH.
// Because of this, a push never finds the FIFO full, whatever rsp_ready does.
//
// Optional feature: define BRAM1BE_CLIENT_WRACK_EN to track writes as well.
// Each write then returns the merged post-write word from BRAM DO.
// By default only reads produce a response.
module bram1be_client #(
    parameter int PIPELINED  = 0,
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int CHUNKSIZE  = 1,
    parameter int WE_WIDTH   = 1,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    bram1be_client_if.slave       bus,
    output logic                  idle,
    output logic                  bram_en,
    output logic [WE_WIDTH-1:0]   bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
);

    // BRAM read latency in cycles.
    localparam int L  = 1 + PIPELINED;
    // FIFO pointer width; RESP_DEPTH is a power of two >= 2, so pointers wrap naturally.
    localparam int PW = $clog2(RESP_DEPTH);
    // FIFO occupancy width; it must be able to hold RESP_DEPTH itself.
    localparam int CW = $clog2(RESP_DEPTH + 1);
    // Width of the credit sum (in-flight tags + FIFO occupancy).
    localparam int SW = $clog2(RESP_DEPTH + L + 1) + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [L-1:0]          tag_q, tag_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [RESP_DEPTH];
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [SW-1:0] inflight;
    logic [SW-1:0] credit_used;
    logic          req_ready_w;
    logic          rsp_valid_w;
    logic          accept;
    logic          tracked;
    logic          push;
    logic          pop;

    // Count the outstanding tags and decide whether one more request fits.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < L; i++) begin
            inflight = inflight + SW'(tag_q[i]);
        end
        credit_used = inflight + SW'(count_q);
        req_ready_w = !RST && (credit_used < SW'(RESP_DEPTH));
    end

    // Decide which accepted requests expect a word back from the BRAM.
    always_comb begin
`ifdef BRAM1BE_CLIENT_WRACK_EN
        tracked = 1'b1;
`else
        tracked = (bus.req_we == '0);
`endif
    end

    assign accept      = bus.req_valid && req_ready_w;
    assign rsp_valid_w = (count_q != '0);
    // The oldest tag marks the cycle in which BRAM DO holds the answer.
    assign push        = tag_q[L-1];
    assign pop         = rsp_valid_w && bus.rsp_ready;

    assign bus.req_ready = req_ready_w;
    assign bus.rsp_valid = rsp_valid_w;
    assign bus.rsp_data  = rsp_data_q;

    // Pass the accepted request straight to the BRAM port. EN alone qualifies it.
    always_comb begin
        bram_en   = accept;
        bram_we   = bus.req_we;
        bram_addr = bus.req_addr;
        bram_di   = bus.req_wdata;
    end

    assign idle = (inflight == '0) && (count_q == '0);

    // Advance the latency tracker: the new tag enters at bit 0, the oldest leaves at bit L-1.
    always_comb begin
        tag_d = (tag_q << 1) | L'(accept && tracked);
    end

    // Update the FIFO pointers and occupancy. A simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Write the captured BRAM word into the FIFO storage.
    always_comb begin
        for (int i = 0; i < RESP_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = bram_do;
        end
    end

    // Register the word that will sit at the FIFO head next cycle.
    // If that entry is being pushed right now, its data comes from BRAM DO
    // and not from storage. With an empty FIFO the last value is held.
    always_comb begin
        rsp_data_d = rsp_data_q;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                rsp_data_d = bram_do;
            end else begin
                rsp_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Tracker and FIFO control state. Reset drops in-flight tags, so a late BRAM DO is ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RESP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RESP_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_bram1be_client.sv
// Bench for bram1be_client.
// A behavioural BRAM1BE (write-first, byte enables) is attached to the
// BRAM port. A reference model predicts the response stream from the
// request stream alone:
//   - A memory image is updated at each request accept.
//   - An expected-data queue holds one word per tracked request, with its
//     accept cycle, which gives the L+1 cycle response time.
//   - The credit rule fixes when requests may be accepted.
module tb_bram1be_client;
    localparam int PIPELINED = 0;
    localparam int AW        = 4;
    localparam int DW        = 32;
    localparam int CS        = 8;
    localparam int WW        = 4;
    localparam int DEPTH     = 4;
    localparam int L         = 1 + PIPELINED;
`ifdef BRAM1BE_CLIENT_WRACK_EN
    localparam bit WRACK = 1'b1;
`else
    localparam bit WRACK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram1be_client_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW)) bif ();

    logic          idle;
    logic          bram_en;
    logic [WW-1:0] bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_di;
    logic [DW-1:0] bram_do;

    bram1be_client #(
        .PIPELINED (PIPELINED),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CHUNKSIZE (CS),
        .WE_WIDTH  (WW),
        .RESP_DEPTH(DEPTH)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .bus      (bif),
        .idle     (idle),
        .bram_en  (bram_en),
        .bram_we  (bram_we),
        .bram_addr(bram_addr),
        .bram_di  (bram_di),
        .bram_do  (bram_do)
    );

    // Returns the word after a byte-enable write: written lanes take new data, the rest keep old data.
    function automatic logic [DW-1:0] merge(logic [DW-1:0] old_w, logic [WW-1:0] we, logic [DW-1:0] new_w);
        logic [DW-1:0] r;
        r = old_w;
        for (int k = 0; k < WW; k++) begin
            if (we[k]) r[k*CS +: CS] = new_w[k*CS +: CS];
        end
        return r;
    endfunction

    // ---------------- behavioural BRAM1BE (write-first) ----------------
    logic [DW-1:0] bram_mem [16];
    logic [DW-1:0] do_r;
    logic [DW-1:0] do_p;
    always @(posedge clk) begin
        if (bram_en) begin
            bram_mem[bram_addr] <= merge(bram_mem[bram_addr], bram_we, bram_di);
            do_r                <= merge(bram_mem[bram_addr], bram_we, bram_di);
        end
        do_p <= do_r;
    end
    assign bram_do = (PIPELINED != 0) ? do_p : do_r;

    // ---------------- scoreboard / reference model ----------------
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] exp_q [$];
    int            acc_q [$];
    int            cyc = 0;
    bit            last_acc;
    int            pop_cnt = 0;
    int            last_pop_cyc;
    int            last_acc_cyc;
    int            run = 0;
    int            max_run = 0;
    logic [DW-1:0] last_rsp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle. Called at a falling edge with the inputs already set.
    // Compares the outputs with the model, then records the handshakes the
    // next rising edge will perform.
    task automatic cycle();
        bit            acc;
        bit            pop;
        logic [DW-1:0] w;
        #1;
        check("idle", idle, exp_q.size() == 0);
        check("req_ready", bif.req_ready, exp_q.size() < DEPTH);
        check("rsp_valid", bif.rsp_valid, (exp_q.size() > 0) && (cyc >= acc_q[0] + L + 1));
        acc = bif.req_valid && bif.req_ready;
        pop = bif.rsp_valid && bif.rsp_ready;
        if (pop) begin
            check("rsp_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check("rsp_data", bif.rsp_data, exp_q.pop_front());
                void'(acc_q.pop_front());
            end
            pop_cnt++;
            last_pop_cyc = cyc;
            last_rsp     = bif.rsp_data;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (acc) begin
            w = merge(ref_mem[bif.req_addr], bif.req_we, bif.req_wdata);
            ref_mem[bif.req_addr] = w;
            if (WRACK || (bif.req_we == '0)) begin
                exp_q.push_back(w);
                acc_q.push_back(cyc);
            end
            last_acc_cyc = cyc;
        end
        last_acc = acc;
        @(negedge clk);
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [WW-1:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bif.req_valid = 1'b1;
        bif.req_we    = we;
        bif.req_addr  = addr;
        bif.req_wdata = data;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (last_acc) break;
        end
        check("issue_acc", last_acc, 1);
        bif.req_valid = 1'b0;
    endtask

    task automatic drain();
        bif.req_valid = 1'b0;
        bif.rsp_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle();
        check("drain", exp_q.size(), 0);
        repeat (L + 2) cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        int p0;
        bif.req_valid = 1'b0;
        bif.req_we    = '0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        bif.rsp_ready = 1'b0;

        // Reset state.
        @(negedge clk);
        #1;
        check("rst_rsp_valid", bif.rsp_valid, 0);
        check("rst_idle", idle, 1);
        check("rst_req_ready", bif.req_ready, 0);
        check("rst_rsp_data", bif.rsp_data, 0);
        check("rst_bram_en", bram_en, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fill every word with known random data.
        for (int a = 0; a < 16; a++) issue(4'hF, AW'(a), $urandom);
        drain();

        // Full write then read: data and accept-to-response latency.
        issue(4'hF, 4'd5, 32'hA1B2C3D4);
        drain();
        bif.rsp_ready = 1'b1;
        issue(4'h0, 4'd5, '0);
        p0 = last_acc_cyc;
        drain();
        check("rd5_data", last_rsp, 32'hA1B2C3D4);
        check("rd5_latency", last_pop_cyc - p0, L + 1);

        // Partial write through byte enables.
        issue(4'hF, 4'd7, 32'hAABBCCDD);
        issue(4'h5, 4'd7, 32'h11223344);
        drain();
        issue(4'h0, 4'd7, '0);
        drain();
        check("be_data", last_rsp, 32'hAA22CC44);

        // Write response only when writes are tracked.
        issue(4'hF, 4'd9, 32'hAABBCCDD);
        drain();
        p0 = pop_cnt;
        issue(4'h5, 4'd9, 32'h11223344);
        drain();
        check("wrack_cnt", pop_cnt - p0, WRACK ? 1 : 0);
        if (WRACK) check("wrack_data", last_rsp, 32'hAA22CC44);

        // Backpressure: with rsp_ready low, only DEPTH reads are accepted.
        bif.rsp_ready = 1'b0;
        bif.req_valid = 1'b1;
        bif.req_we    = '0;
        bif.req_addr  = '0;
        cnt = 0;
        repeat (8) begin
            cycle();
            if (last_acc) begin
                cnt++;
                bif.req_addr = AW'(cnt);
                if (cnt == 6) bif.req_valid = 1'b0;
            end
        end
        check("bp_accepted", cnt, DEPTH);
        check("bp_ready_low", bif.req_ready, 0);
        bif.rsp_ready = 1'b1;
        for (int i = 0; i < 40 && cnt < 6; i++) begin
            cycle();
            if (last_acc) begin
                cnt++;
                bif.req_addr = AW'(cnt);
                if (cnt == 6) bif.req_valid = 1'b0;
            end
        end
        check("bp_all", cnt, 6);
        drain();

        // Streaming: 16 back-to-back reads give 16 back-to-back responses.
        bif.rsp_ready = 1'b1;
        max_run = 0;
        run     = 0;
        cnt     = 0;
        for (int a = 0; a < 16; a++) begin
            bif.req_valid = 1'b1;
            bif.req_we    = '0;
            bif.req_addr  = AW'(a);
            cycle();
            if (last_acc) cnt++;
        end
        bif.req_valid = 1'b0;
        drain();
        check("stream_acc", cnt, 16);
        check("stream_run", max_run, 16);

        // Reset while two reads are in flight.
        bif.rsp_ready = 1'b0;
        issue(4'h0, 4'd1, '0);
        issue(4'h0, 4'd2, '0);
        rst = 1'b1;
        bif.req_valid = 1'b1;
        #1;
        check("mid_rst_rsp_valid", bif.rsp_valid, 0);
        check("mid_rst_idle", idle, 1);
        check("mid_rst_req_ready", bif.req_ready, 0);
        check("mid_rst_bram_en", bram_en, 0);
        exp_q.delete();
        acc_q.delete();
        repeat (3) @(negedge clk);
        bif.req_valid = 1'b0;
        bif.rsp_ready = 1'b1;
        rst = 1'b0;
        repeat (6) cycle();

        // Random traffic with random response backpressure.
        for (int i = 0; i < 400; i++) begin
            bif.req_valid = 1'($urandom_range(0, 1));
            bif.req_we    = ($urandom_range(0, 1) == 0) ? '0 : WW'($urandom);
            bif.req_addr  = AW'($urandom);
            bif.req_wdata = $urandom;
            bif.rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: stops the run if it ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
